// File: rtl/clock_reset_sequencer.sv
// rtl/clock_reset_sequencer.sv - power-up clock manager and core reset sequencer
// Runs on the free-running oscillator clock; lock is the only asynchronous input.
module clock_reset_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 4096,
  parameter int STABLE_CYCLES  = 256,
  parameter int SW_RST_CYCLES  = 16,
  parameter int MAX_RETRY      = 3,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       locked,
  input  logic       sw_rst_req,
  output logic       clk_mgr_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       lock_fail,
  output logic [3:0] retry_cnt,
  output logic [2:0] state
);

  localparam logic [2:0] S_PLL_RST   = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_SWRST     = 3'd4;
  localparam logic [2:0] S_FAIL      = 3'd5;

  localparam logic [CNT_W-1:0] PLL_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SWRST_LAST  = CNT_W'(SW_RST_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRY);

  logic             locked_m;
  logic             locked_s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nxt_cnt;
  logic [2:0]       nxt_state;
  logic [3:0]       nxt_retry;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked_m <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      locked_m <= locked;
      locked_s <= locked_m;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_retry = retry_cnt;
    case (state)
      S_PLL_RST: begin
        if (cnt == PLL_LAST) nxt_state = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          nxt_state = S_STABLE;
        end else if (cnt == LOCK_LAST) begin
          if (retry_cnt == RETRY_LIMIT) begin
            nxt_state = S_FAIL;
          end else begin
            nxt_state = S_PLL_RST;
            nxt_retry = retry_cnt + 4'd1;
          end
        end
      end
      S_STABLE: begin
        if (!locked_s)                nxt_state = S_WAIT_LOCK;
        else if (cnt == STABLE_LAST)  nxt_state = S_RUN;
      end
      S_RUN: begin
        // Lock loss in RUN starts a fresh sequence with a full retry budget.
        if (!locked_s) begin
          nxt_state = S_PLL_RST;
          nxt_retry = 4'd0;
        end else if (sw_rst_req) begin
          nxt_state = S_SWRST;
        end
      end
      S_SWRST: begin
        if (!locked_s)               nxt_state = S_PLL_RST;
        else if (cnt == SWRST_LAST)  nxt_state = S_RUN;
      end
      S_FAIL: begin
        nxt_state = S_FAIL;
      end
      default: begin
        nxt_state = S_PLL_RST;
        nxt_retry = 4'd0;
      end
    endcase
    nxt_cnt = (nxt_state != state) ? '0 : cnt + 1'b1;
  end

  // Outputs decode next-state so they move on the same edge as state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_PLL_RST;
      cnt         <= '0;
      retry_cnt   <= 4'd0;
      clk_mgr_rst <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      lock_fail   <= 1'b0;
    end else begin
      state       <= nxt_state;
      cnt         <= nxt_cnt;
      retry_cnt   <= nxt_retry;
      clk_mgr_rst <= (nxt_state == S_PLL_RST) || (nxt_state == S_FAIL);
      sys_rst     <= (nxt_state != S_RUN);
      ready       <= (nxt_state == S_RUN);
      lock_fail   <= (nxt_state == S_FAIL);
    end
  end

endmodule

// File: tb/tb_clock_reset_sequencer.sv
// tb/tb_clock_reset_sequencer.sv - scoreboard bench for clock_reset_sequencer
module tb_clock_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       locked;
  logic       sw_rst_req;
  logic       clk_mgr_rst;
  logic       sys_rst;
  logic       ready;
  logic       lock_fail;
  logic [3:0] retry_cnt;
  logic [2:0] state;

  clock_reset_sequencer #(
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8),
    .SW_RST_CYCLES (4),
    .MAX_RETRY     (2),
    .CNT_W         (16)
  ) dut (
    .clk        (clk),
    .reset      (rst),
    .locked     (locked),
    .sw_rst_req (sw_rst_req),
    .clk_mgr_rst(clk_mgr_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .lock_fail  (lock_fail),
    .retry_cnt  (retry_cnt),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         c;
    logic [2:0] st;
    logic       cmr;
    logic       sys;
    logic       rdy;
    logic       lf;
    logic [3:0] rc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc;
  logic mon_en = 1'b0;
  logic [2:0] prev_state;

  // Edge counter: edge k after reset release leaves cyc == k.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic push(input int c, input logic [2:0] st, input logic cmr, input logic sys,
                      input logic rdy, input logic lf, input logic [3:0] rc);
    exp_t e;
    e.c = c; e.st = st; e.cmr = cmr; e.sys = sys; e.rdy = rdy; e.lf = lf; e.rc = rc;
    q.push_back(e);
  endtask

  // Monitor: every state change observed must match the next scoreboard entry.
  always @(negedge clk) begin
    if (mon_en) begin
      if (state !== prev_state) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_transition: cyc=%0d state %0d -> %0d, required no change",
                   cyc, prev_state, state);
        end else begin
          exp_t e;
          e = q.pop_front();
          if ((e.c >= 0 && cyc != e.c) || state !== e.st || clk_mgr_rst !== e.cmr ||
              sys_rst !== e.sys || ready !== e.rdy || lock_fail !== e.lf || retry_cnt !== e.rc) begin
            n_fail++;
            $display("FAIL transition: got cyc=%0d st=%0d cmr=%b sys=%b rdy=%b lf=%b rc=%0d, required cyc=%0d st=%0d cmr=%b sys=%b rdy=%b lf=%b rc=%0d",
                     cyc, state, clk_mgr_rst, sys_rst, ready, lock_fail, retry_cnt,
                     e.c, e.st, e.cmr, e.sys, e.rdy, e.lf, e.rc);
          end
        end
      end
    end
    prev_state = state;
  end

  task automatic at_cyc(input int n);
    int g = 0;
    while (cyc != n && g < 2000) begin
      @(posedge clk); #1;
      g++;
    end
    if (cyc != n) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_timeout: cyc=%0d, required %0d", cyc, n);
    end
  endtask

  task automatic check_reset_vals(input string name);
    n_tests++;
    if ({state, clk_mgr_rst, sys_rst, ready, lock_fail, retry_cnt} !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL %s: got st=%0d cmr=%b sys=%b rdy=%b lf=%b rc=%0d, required st=0 cmr=1 sys=1 rdy=0 lf=0 rc=0",
               name, state, clk_mgr_rst, sys_rst, ready, lock_fail, retry_cnt);
    end
  endtask

  task automatic release_rst();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic assert_rst(input string name);
    push(-1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    rst = 1'b1;
    #1 check_reset_vals(name);
  endtask

  initial begin
    rst = 1'b1; locked = 1'b0; sw_rst_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_vals("initial_reset");
    @(negedge clk);
    mon_en = 1'b1;

    // Power-up, lock after edge 10, then software reset, then lock loss in RUN.
    push(4,  3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    push(13, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    push(21, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    push(26, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    push(30, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    push(38, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    push(42, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    push(43, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    push(51, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    push(61, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    release_rst();
    at_cyc(10); locked = 1'b1;
    at_cyc(25); sw_rst_req = 1'b1;
    at_cyc(26); sw_rst_req = 1'b0;
    at_cyc(35); locked = 1'b0;
    at_cyc(38); locked = 1'b1;
    at_cyc(60); sw_rst_req = 1'b1;
    at_cyc(61); sw_rst_req = 1'b0;

    // Reset mid-SWRST, then mid-STABLE.
    at_cyc(62);
    assert_rst("reset_mid_swrst");
    push(4, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    push(5, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    release_rst();
    at_cyc(7);
    assert_rst("reset_mid_stable");
    locked = 1'b0;

    // One retry, then ignored sw request and short lock drop in STABLE.
    push(4,  3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    push(36, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
    push(40, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
    push(43, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
    push(49, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
    push(51, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
    push(59, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1);
    release_rst();
    at_cyc(40); locked = 1'b1;
    at_cyc(44); sw_rst_req = 1'b1;
    at_cyc(45); sw_rst_req = 1'b0;
    at_cyc(46); locked = 1'b0;
    at_cyc(48); locked = 1'b1;
    at_cyc(65);
    assert_rst("reset_in_run");
    locked = 1'b0;

    // Lock never arrives: retries exhaust into FAIL.
    push(4,   3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    push(36,  3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
    push(40,  3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
    push(72,  3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2);
    push(76,  3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
    push(108, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1, 4'd2);
    release_rst();
    at_cyc(110); sw_rst_req = 1'b1;
    at_cyc(111); sw_rst_req = 1'b0; locked = 1'b1;
    at_cyc(150);
    n_tests++;
    if ({state, lock_fail, clk_mgr_rst, sys_rst} !== {3'd5, 1'b1, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL fail_sticky: got st=%0d lf=%b cmr=%b sys=%b, required st=5 lf=1 cmr=1 sys=1",
               state, lock_fail, clk_mgr_rst, sys_rst);
    end
    assert_rst("reset_from_fail");
    repeat (2) @(negedge clk);

    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
